// File: rtl/arq_pkg.sv
// -----------------------------------------------------------------------------
// arq_pkg
// Shared definitions for the sender ARQ sequencer: FSM state encodings (also
// decoded by tran_rec and the debug LEDs), default parameter values and a
// small helper that tells which states stall the mapper.
// -----------------------------------------------------------------------------
package arq_pkg;

    // Encodings are fixed because o_state is decoded outside this block.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LIVE   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPLAY = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_FAIL   = 3'd5
    } arq_state_t;

    localparam int FRAME_BYTES_DEF = 64;      // bytes per frame, FAS included
    localparam int ACK_TIMEOUT_DEF = 100000;  // cycles before implicit NACK
    localparam int MAX_RETRIES_DEF = 3;       // replays allowed per frame
    localparam int TMR_W_DEF       = 17;      // 2**TMR_W > ACK_TIMEOUT
    localparam int RETRY_W         = 2;       // width of the retry counter

    // Every state except IDLE and LIVE keeps the mapper stalled.
    function automatic logic holds_mapper(input arq_state_t st);
        return (st == ST_WAIT)  || (st == ST_REPLAY) ||
               (st == ST_FLUSH) || (st == ST_FAIL);
    endfunction

endpackage

// File: rtl/arq_timer.sv
// -----------------------------------------------------------------------------
// arq_timer
// Loadable down-counter that times the ACK window.
//   i_clk       system clock
//   i_rst       asynchronous, active-high reset
//   i_load      load i_load_val (takes priority over i_dec)
//   i_dec       decrement by one, saturating at zero
//   i_load_val  value loaded on i_load
//   o_zero      registered: high from the cycle after the count sat at zero
// The zero flag lags the count by one cycle, so the cycle in which the count
// sits at zero still belongs to the ACK window; an ACK there beats the
// timeout, and the window is ACK_TIMEOUT+1 cycles counted from WAIT entry.
// -----------------------------------------------------------------------------
module arq_timer
    import arq_pkg::*;
#(
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_cnt;
    logic             r_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_load_val;
            r_zero <= 1'b0;
        end else if (i_dec) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - TMR_W'(1);
            end
            r_zero <= (r_cnt == '0);
        end
    end

    assign o_zero = r_zero;

endmodule

// File: rtl/arq_ctrl.sv
// -----------------------------------------------------------------------------
// arq_ctrl
// Sequencer for the sender ARQ path between mapper, line FIFO and tran_rec.
// Chooses live mapper data or line FIFO replay for tran_rec, stalls the mapper
// while a frame is unacknowledged, runs the ACK timeout and retry count, and
// pulses the line FIFO flush after a good ACK (or an abandoned frame).
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_arq_en     ARQ switch; 0 = pass-through, no ACK wait
//   i_map_valid  mapper byte accepted by tran_rec this cycle
//   i_map_fas    qualifies i_map_valid: byte is first of frame
//   i_lf_valid   line FIFO has output data
//   i_tr_ready   tran_rec input FIFO can take a byte
//   i_ack_good   1-cycle ACK pulse
//   i_ack_bad    1-cycle NACK pulse (wins over a simultaneous ACK)
//   i_clr_fail   1-cycle pulse: leave FAIL
//   o_map_hold   stall mapper
//   o_sel_lf     1 = tran_rec fed from line FIFO
//   o_lf_rd      line FIFO tready (combinational so no byte is lost)
//   o_lf_flush   1-cycle line FIFO reset pulse
//   o_retry_cnt  replays done for the current frame
//   o_fail       retry limit exhausted
//   o_state      FSM state for debug LEDs
// All outputs except o_lf_rd are registered from the next-state decode.
// -----------------------------------------------------------------------------
module arq_ctrl
    import arq_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int MAX_RETRIES = MAX_RETRIES_DEF,
    parameter int TMR_W       = TMR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_arq_en,
    input  logic               i_map_valid,
    input  logic               i_map_fas,
    input  logic               i_lf_valid,
    input  logic               i_tr_ready,
    input  logic               i_ack_good,
    input  logic               i_ack_bad,
    input  logic               i_clr_fail,
    output logic               o_map_hold,
    output logic               o_sel_lf,
    output logic               o_lf_rd,
    output logic               o_lf_flush,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_fail,
    output logic [2:0]         o_state
);

    localparam int                 CNT_W     = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    arq_state_t         r_state;
    arq_state_t         w_next_state;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic               r_map_hold;
    logic               r_sel_lf;
    logic               r_lf_flush;
    logic               r_fail;

    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_retry_inc;
    logic               w_retry_clr;
    logic               w_tmr_load;
    logic               w_tmr_dec;
    logic               w_tmr_zero;
    logic               w_lf_hs;

    assign w_tmr_dec = (r_state == ST_WAIT);
    // Replay bytes count only on a real line FIFO handshake.
    assign w_lf_hs   = i_lf_valid && i_tr_ready;

    arq_timer #(
        .TMR_W      (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_dec      (w_tmr_dec),
        .i_load_val (TMR_LOAD),
        .o_zero     (w_tmr_zero)
    );

    // Next-state and counter-control decode.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_tmr_load   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The FAS byte is byte 0; non-FAS bytes here are ignored.
                if (i_map_valid && i_map_fas) begin
                    w_next_state = ST_LIVE;
                    w_cnt_inc    = 1'b1;
                end
            end

            ST_LIVE: begin
                if (i_map_valid) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_cnt_clr = 1'b1;
                        // arq_en is looked at only here, at frame end.
                        if (i_arq_en) begin
                            w_next_state = ST_WAIT;
                            w_tmr_load   = 1'b1;
                        end else begin
                            w_next_state = ST_FLUSH;
                        end
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                // Priority: abandon > NACK (even with ACK) > ACK > timeout.
                // An ACK in the timeout cycle therefore still flushes.
                if (!i_arq_en) begin
                    w_next_state = ST_FLUSH;
                end else if (i_ack_bad || (!i_ack_good && w_tmr_zero)) begin
                    if (r_retry == RETRY_MAX) begin
                        w_next_state = ST_FAIL;
                    end else begin
                        w_next_state = ST_REPLAY;
                        w_retry_inc  = 1'b1;
                        w_cnt_clr    = 1'b1;
                    end
                end else if (i_ack_good) begin
                    w_next_state = ST_FLUSH;
                end
            end

            ST_REPLAY: begin
                // No timeout here: an empty line FIFO simply stalls.
                if (!i_arq_en) begin
                    w_next_state = ST_FLUSH;
                end else if (w_lf_hs) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_next_state = ST_WAIT;
                        w_tmr_load   = 1'b1;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                w_next_state = ST_IDLE;
                w_retry_clr  = 1'b1;
            end

            ST_FAIL: begin
                if (!i_arq_en || i_clr_fail) begin
                    w_next_state = ST_FLUSH;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_cnt_clr    = 1'b1;
                w_retry_clr  = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_retry    <= '0;
            r_map_hold <= 1'b0;
            r_sel_lf   <= 1'b0;
            r_lf_flush <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state    <= w_next_state;
            r_map_hold <= holds_mapper(w_next_state);
            r_sel_lf   <= (w_next_state == ST_REPLAY);
            r_lf_flush <= (w_next_state == ST_FLUSH);
            r_fail     <= (w_next_state == ST_FAIL);

            if (w_cnt_clr) begin
                r_byte_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end

            if (w_retry_clr) begin
                r_retry <= '0;
            end else if (w_retry_inc && (r_retry != RETRY_MAX)) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
        end
    end

    assign o_map_hold  = r_map_hold;
    assign o_sel_lf    = r_sel_lf;
    assign o_lf_flush  = r_lf_flush;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry;
    assign o_state     = r_state;
    // Combinational so the read strobe tracks i_tr_ready in the same cycle.
    assign o_lf_rd     = (r_state == ST_REPLAY) && i_tr_ready;

endmodule

// File: tb/tb_arq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arq_ctrl
// Self-checking bench for arq_ctrl with FRAME_BYTES=8, ACK_TIMEOUT=20,
// MAX_RETRIES=3. Expected behaviour comes from frame-level rules: the ACK
// window is ACK_TIMEOUT+1 cycles, a replay ends on the FRAME_BYTES-th
// valid&ready handshake, o_lf_rd mirrors i_tr_ready in REPLAY.
// -----------------------------------------------------------------------------
module tb_arq_ctrl;
    import arq_pkg::*;

    localparam int FB  = 8;
    localparam int ATO = 20;
    localparam int MR  = 3;
    localparam int TW  = 5;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_arq_en;
    logic               i_map_valid;
    logic               i_map_fas;
    logic               i_lf_valid;
    logic               i_tr_ready;
    logic               i_ack_good;
    logic               i_ack_bad;
    logic               i_clr_fail;
    logic               o_map_hold;
    logic               o_sel_lf;
    logic               o_lf_rd;
    logic               o_lf_flush;
    logic [RETRY_W-1:0] o_retry_cnt;
    logic               o_fail;
    logic [2:0]         o_state;

    int n_checks = 0;
    int n_errors = 0;

    arq_ctrl #(
        .FRAME_BYTES (FB),
        .ACK_TIMEOUT (ATO),
        .MAX_RETRIES (MR),
        .TMR_W       (TW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_arq_en    (i_arq_en),
        .i_map_valid (i_map_valid),
        .i_map_fas   (i_map_fas),
        .i_lf_valid  (i_lf_valid),
        .i_tr_ready  (i_tr_ready),
        .i_ack_good  (i_ack_good),
        .i_ack_bad   (i_ack_bad),
        .i_clr_fail  (i_clr_fail),
        .o_map_hold  (o_map_hold),
        .o_sel_lf    (o_sel_lf),
        .o_lf_rd     (o_lf_rd),
        .o_lf_flush  (o_lf_flush),
        .o_retry_cnt (o_retry_cnt),
        .o_fail      (o_fail),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    // Advance one clock; inputs set afterwards apply to the next edge and
    // outputs read afterwards reflect the edge just taken.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_map_valid = 1'b0; i_map_fas  = 1'b0; i_lf_valid = 1'b0;
        i_tr_ready  = 1'b0; i_ack_good = 1'b0; i_ack_bad  = 1'b0;
        i_clr_fail  = 1'b0;
    endtask

    // Mapper bytes first..last with random idle gaps; byte 0 carries FAS.
    task automatic send_bytes(input int first, input int last, input int max_gap);
        for (int b = first; b <= last; b++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            i_map_valid = 1'b1;
            i_map_fas   = (b == 0);
            tick();
            i_map_valid = 1'b0;
            i_map_fas   = 1'b0;
        end
    endtask

    // From WAIT entry: drive an ACK/NACK at cycle ack_at (-1 = never) and
    // count cycles until the FSM leaves WAIT (bounded).
    task automatic wait_exit(input int ack_at, input bit good, input bit bad,
                             output int cycles);
        cycles = 0;
        while (o_state == ST_WAIT && cycles < 200) begin
            i_ack_good = good && (cycles == ack_at);
            i_ack_bad  = bad  && (cycles == ack_at);
            tick();
            cycles++;
        end
        i_ack_good = 1'b0;
        i_ack_bad  = 1'b0;
    endtask

    // Cleanup: ACK in WAIT, then step through FLUSH into IDLE.
    task automatic ack_to_idle();
        i_ack_good = 1'b1; tick(); i_ack_good = 1'b0; tick();
    endtask

    // Replay a frame under random valid/ready; checks o_lf_rd each cycle and
    // that WAIT follows exactly the FB-th handshake.
    task automatic drive_replay(input int valid_pct, input int ready_pct, input string tag);
        int hs  = 0;
        int cyc = 0;
        while (hs < FB && cyc < 400) begin
            bit v;
            bit r;
            v = ($urandom_range(99, 0) < valid_pct);
            r = ($urandom_range(99, 0) < ready_pct);
            i_lf_valid = v;
            i_tr_ready = r;
            #1;
            n_checks++;
            if ({o_state, o_sel_lf, o_map_hold, o_lf_rd} !== {ST_REPLAY, 1'b1, 1'b1, r}) begin
                n_errors++;
                $display("FAIL %s_replay_cycle%0d: got state=%0d sel=%b hold=%b rd=%b, expected state=3 sel=1 hold=1 rd=%b",
                         tag, cyc, o_state, o_sel_lf, o_map_hold, o_lf_rd, r);
            end
            if (v && r) hs++;
            tick();
            cyc++;
        end
        i_lf_valid = 1'b0;
        i_tr_ready = 1'b0;
        n_checks++;
        if (hs < FB || o_state !== ST_WAIT || o_sel_lf !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_replay_end: got handshakes=%0d state=%0d sel=%b, expected handshakes=%0d state=2 sel=0",
                     tag, hs, o_state, o_sel_lf, FB);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        i_arq_en   = 1'b1;
        i_tr_ready = 1'b1;
        i_rst      = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_state, o_map_hold, o_sel_lf, o_lf_rd, o_lf_flush, o_retry_cnt, o_fail} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got state=%0d hold=%b sel=%b rd=%b flush=%b retry=%0d fail=%b, expected all 0",
                     o_state, o_map_hold, o_sel_lf, o_lf_rd, o_lf_flush, o_retry_cnt, o_fail);
        end
        i_rst      = 1'b0;
        i_tr_ready = 1'b0;
        tick();
        n_checks++;
        if (o_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_release: got state=%0d, expected 0", o_state);
        end
    endtask

    task automatic test_good_frame();
        int c;
        // Non-FAS bytes in IDLE must not start a frame.
        send_bytes(1, 1 + $urandom_range(2, 0), 1);
        n_checks++;
        if (o_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL good_nonfas_idle: got state=%0d, expected 0", o_state);
        end
        send_bytes(0, FB - 1, 2);
        n_checks++;
        if (o_state !== ST_WAIT || o_map_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL good_wait_entry: got state=%0d hold=%b, expected state=2 hold=1", o_state, o_map_hold);
        end
        wait_exit(5, 1'b1, 1'b0, c);
        n_checks++;
        if (c !== 6 || o_state !== ST_FLUSH || o_lf_flush !== 1'b1) begin
            n_errors++;
            $display("FAIL good_flush: got cycles=%0d state=%0d flush=%b, expected cycles=6 state=4 flush=1",
                     c, o_state, o_lf_flush);
        end
        tick();
        n_checks++;
        if ({o_state, o_lf_flush, o_map_hold, o_retry_cnt} !== {ST_IDLE, 1'b0, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL good_idle: got state=%0d flush=%b hold=%b retry=%0d, expected 0/0/0/0",
                     o_state, o_lf_flush, o_map_hold, o_retry_cnt);
        end
    endtask

    task automatic test_nack();
        int c;
        int d;
        d = $urandom_range(ATO - 1, 0);
        send_bytes(0, FB - 1, 1);
        wait_exit(d, 1'b0, 1'b1, c);
        n_checks++;
        if (c !== d + 1 || o_state !== ST_REPLAY || o_sel_lf !== 1'b1 || o_retry_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL nack_replay: got cycles=%0d state=%0d sel=%b retry=%0d, expected cycles=%0d state=3 sel=1 retry=1",
                     c, o_state, o_sel_lf, o_retry_cnt, d + 1);
        end
        drive_replay(100, 100, "nack");
        n_checks++;
        if (o_retry_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL nack_retry_after: got %0d, expected 1", o_retry_cnt);
        end
        ack_to_idle();
    endtask

    task automatic test_timeout();
        int c;
        send_bytes(0, FB - 1, 0);
        for (int r = 1; r <= MR + 1; r++) begin
            wait_exit(-1, 1'b0, 1'b0, c);
            n_checks++;
            if (r <= MR) begin
                if (c !== ATO + 1 || o_state !== ST_REPLAY || o_retry_cnt !== RETRY_W'(r)) begin
                    n_errors++;
                    $display("FAIL timeout_%0d: got cycles=%0d state=%0d retry=%0d, expected cycles=%0d state=3 retry=%0d",
                             r, c, o_state, o_retry_cnt, ATO + 1, r);
                end
                drive_replay(70, 70, "timeout");
            end else begin
                if (c !== ATO + 1 || o_state !== ST_FAIL || o_fail !== 1'b1 ||
                    o_retry_cnt !== RETRY_W'(MR) || o_map_hold !== 1'b1) begin
                    n_errors++;
                    $display("FAIL timeout_fail: got cycles=%0d state=%0d fail=%b retry=%0d hold=%b, expected %0d/5/1/%0d/1",
                             c, o_state, o_fail, o_retry_cnt, o_map_hold, ATO + 1, MR);
                end
            end
        end
        repeat (5) tick();
        n_checks++;
        if (o_state !== ST_FAIL) begin
            n_errors++;
            $display("FAIL fail_sticky: got state=%0d, expected 5", o_state);
        end
        i_clr_fail = 1'b1; tick(); i_clr_fail = 1'b0;
        n_checks++;
        if (o_state !== ST_FLUSH || o_lf_flush !== 1'b1 || o_fail !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_fail_flush: got state=%0d flush=%b fail=%b, expected 4/1/0", o_state, o_lf_flush, o_fail);
        end
        tick();
        n_checks++;
        if (o_state !== ST_IDLE || o_retry_cnt !== 2'd0 || o_lf_flush !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_fail_idle: got state=%0d retry=%0d flush=%b, expected 0/0/0", o_state, o_retry_cnt, o_lf_flush);
        end
    endtask

    task automatic test_backpressure();
        int c;
        for (int k = 0; k < 3; k++) begin
            send_bytes(0, FB - 1, 1);
            wait_exit(0, 1'b0, 1'b1, c);
            drive_replay(60, 50, "bp");
            ack_to_idle();
        end
    endtask

    task automatic test_corners();
        int c;
        // Good and bad together count as NACK.
        send_bytes(0, FB - 1, 0);
        wait_exit(3, 1'b1, 1'b1, c);
        n_checks++;
        if (c !== 4 || o_state !== ST_REPLAY) begin
            n_errors++;
            $display("FAIL both_acks: got cycles=%0d state=%0d, expected cycles=4 state=3", c, o_state);
        end
        drive_replay(100, 100, "both");
        ack_to_idle();
        // ACK in the last cycle of the window beats the timeout.
        send_bytes(0, FB - 1, 0);
        wait_exit(ATO, 1'b1, 1'b0, c);
        n_checks++;
        if (c !== ATO + 1 || o_state !== ST_FLUSH) begin
            n_errors++;
            $display("FAIL ack_on_timeout: got cycles=%0d state=%0d, expected cycles=%0d state=4", c, o_state, ATO + 1);
        end
        tick();
        // ACK pulses in IDLE and LIVE are ignored and not remembered.
        i_ack_bad = 1'b1; tick(); i_ack_bad = 1'b0;
        send_bytes(0, 3, 0);
        i_ack_good = 1'b1; tick(); i_ack_good = 1'b0;
        i_ack_bad  = 1'b1; tick(); i_ack_bad  = 1'b0;
        n_checks++;
        if (o_state !== ST_LIVE || o_map_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_in_live: got state=%0d hold=%b, expected state=1 hold=0", o_state, o_map_hold);
        end
        send_bytes(4, FB - 1, 0);
        wait_exit(3, 1'b1, 1'b0, c);
        n_checks++;
        if (c !== 4 || o_state !== ST_FLUSH) begin
            n_errors++;
            $display("FAIL ack_not_stored: got cycles=%0d state=%0d, expected cycles=4 state=4", c, o_state);
        end
        tick();
    endtask

    task automatic test_random_ack();
        int c;
        int d;
        int kind;
        int exp_c;
        logic [2:0] exp_st;
        for (int k = 0; k < 8; k++) begin
            d    = $urandom_range(ATO + 4, 0);
            kind = $urandom_range(2, 0);          // 0 good, 1 bad, 2 both
            send_bytes(0, FB - 1, 1);
            wait_exit(d, kind != 1, kind != 0, c);
            exp_c  = (d <= ATO) ? d + 1 : ATO + 1;
            exp_st = (d <= ATO && kind == 0) ? ST_FLUSH : ST_REPLAY;
            n_checks++;
            if (c !== exp_c || o_state !== exp_st) begin
                n_errors++;
                $display("FAIL random_ack_%0d: got cycles=%0d state=%0d, expected cycles=%0d state=%0d (d=%0d kind=%0d)",
                         k, c, o_state, exp_c, exp_st, d, kind);
            end
            if (o_state == ST_REPLAY) begin
                drive_replay(80, 80, "rand");
                ack_to_idle();
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        i_arq_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_bytes(0, FB - 1, 0);
            n_checks++;
            if (o_state !== ST_FLUSH || o_lf_flush !== 1'b1 || o_map_hold !== 1'b1) begin
                n_errors++;
                $display("FAIL passthru_%0d: got state=%0d flush=%b hold=%b, expected 4/1/1",
                         k, o_state, o_lf_flush, o_map_hold);
            end
            tick();
        end
        // Enabling mid-LIVE takes effect at this frame's end.
        send_bytes(0, 3, 0);
        i_arq_en = 1'b1;
        send_bytes(4, FB - 1, 0);
        n_checks++;
        if (o_state !== ST_WAIT) begin
            n_errors++;
            $display("FAIL enable_mid_live: got state=%0d, expected 2", o_state);
        end
        // Dropping arq_en in WAIT abandons the frame next cycle.
        repeat ($urandom_range(6, 1)) tick();
        i_arq_en = 1'b0; tick();
        n_checks++;
        if (o_state !== ST_FLUSH || o_lf_flush !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_in_wait: got state=%0d flush=%b, expected 4/1", o_state, o_lf_flush);
        end
        i_arq_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_replay();
        int c;
        send_bytes(0, FB - 1, 0);
        wait_exit(2, 1'b0, 1'b1, c);
        i_lf_valid = 1'b1;
        i_tr_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (o_state !== ST_REPLAY || o_lf_rd !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_replay: got state=%0d rd=%b, expected 3/1", o_state, o_lf_rd);
        end
        i_rst = 1'b1;
        #1;
        n_checks++;
        if ({o_state, o_map_hold, o_sel_lf, o_lf_rd, o_lf_flush, o_retry_cnt, o_fail} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_replay: got state=%0d hold=%b sel=%b rd=%b flush=%b retry=%0d fail=%b, expected all 0",
                     o_state, o_map_hold, o_sel_lf, o_lf_rd, o_lf_flush, o_retry_cnt, o_fail);
        end
        tick();
        i_rst = 1'b0;
        clear_inputs();
        tick();
        n_checks++;
        if (o_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL after_reset: got state=%0d, expected 0", o_state);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_nack();
        test_timeout();
        test_backpressure();
        test_corners();
        test_random_ack();
        test_back_to_back();
        test_reset_mid_replay();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
